rca_seq_ctrl: RTL and testbench
===============================

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port in_valid, input, 1 bit: the requester presents an operation.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 Port op_a, input, W bits: addend or minuend.
REQ-008 Port op_b, input, W bits: addend or subtrahend.
REQ-009 Port sub, input, 1 bit: 1 selects A-B, 0 selects A+B+cin.
REQ-010 Port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-011 Port out_valid, output, 1 bit: the result is available.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port sum, output, W bits: registered result.
REQ-014 Port cout, output, 1 bit: final carry (for sub, 1 = no borrow).
REQ-015 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The block SHALL contain exactly one ripplecarry4bit instance (ports sum, cout, a, b, cin) and SHALL compute all arithmetic through it, one nibble per cycle.
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE SHALL drive in_ready=1 and out_valid=0; every other state SHALL drive in_ready=0.
REQ-019 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-020 On acceptance the block SHALL latch a_reg=op_a and b_reg=(sub ? ~op_b : op_b).
REQ-021 On acceptance the block SHALL set carry_reg=(sub ? 1 : cin) and nibble index idx=0, and SHALL go to RUN.
REQ-022 In RUN, each cycle the adder SHALL receive a_reg[4*idx+3:4*idx], b_reg[4*idx+3:4*idx] and carry_reg.
REQ-023 In RUN, on each edge the adder sum SHALL be written into sum_reg nibble idx, carry_reg SHALL take the adder cout, and idx SHALL increment.
REQ-024 When idx=NIBBLES-1 in RUN, the next edge SHALL enter DONE.
REQ-025 The latency SHALL be exactly NIBBLES RUN cycles: out_valid rises NIBBLES edges after the accept edge (4 for the default).
REQ-026 DONE SHALL drive out_valid=1, and sum, cout and ovf SHALL stay stable until the handshake.
REQ-027 On an edge with out_valid=1 and out_ready=1 the FSM SHALL return to IDLE.
REQ-028 While out_ready=0 the FSM SHALL stay in DONE indefinitely.
REQ-029 An operation SHALL NOT be accepted in the same cycle a result is consumed, since in_ready=0 in DONE; the earliest next accept is the cycle after return to IDLE.
REQ-030 Changes on op_a, op_b, sub and cin after acceptance SHALL NOT affect the operation in progress.
REQ-031 The block SHALL compute ovf = (a_reg[W-1]==b_reg[W-1]) && (sum[W-1]!=a_reg[W-1]), using the effective (possibly inverted) b_reg.
REQ-032 cout SHALL equal the final carry_reg.
REQ-033 Arithmetic SHALL wrap modulo 2^W, with the carry reported only on cout.
REQ-034 in_valid asserted outside IDLE SHALL be ignored without error; the requester holds it until in_ready.

Reset
REQ-035 When rst=1 at a clock edge, the FSM SHALL go to IDLE and idx, carry_reg and sum_reg SHALL clear to 0.
REQ-036 The reset values of the outputs SHALL be in_ready=1, out_valid=0, sum=0, cout=0 and ovf=0, visible after the reset edge.
REQ-037 A reset in RUN or DONE SHALL abort the operation with no result and no out_valid pulse.
REQ-038 rst SHALL take priority over any simultaneous handshake, so an operation presented on a reset edge is not accepted.

Verification
REQ-039 Scenario, add: A=0x1234, B=0x4321, sub=0, cin=0 -> out_valid 4 edges after accept, with sum=0x5555, cout=0 and ovf=0.
REQ-040 Scenario, full carry chain: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0; carry_reg is observed propagating through all 4 nibbles.
REQ-041 Scenario, subtract: A=0x0005, B=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0 and ovf=0, showing that cin is ignored.
REQ-042 Scenario, signed overflow: A=0x7FFF, B=0x0001, add -> sum=0x8000, ovf=1.
REQ-043 Scenario, signed overflow: A=0x8000, B=0x0001, sub -> sum=0x7FFF, ovf=1.
REQ-044 Scenario, backpressure: out_ready=0 for 10 cycles -> out_valid and sum held constant and in_ready=0 throughout; raising out_ready gives IDLE on the next edge, and back-to-back ops are spaced at least 6 cycles.
REQ-045 Scenario, mid-op reset: rst pulsed 2 cycles after accept -> in_ready=1, out_valid=0 and sum=0; a following op A=0x0001, B=0x0001 returns sum=0x0002.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// Sequential W-bit add/subtract built on one 4-bit ripple-carry adder,
// processing one nibble per clock with a valid/ready handshake on each side.

module ripplecarry4bit (
    output logic [3:0] sum,
    output logic       cout,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

// State table:
//   IDLE | waiting for an operation, in_ready=1
//   RUN  | one nibble per cycle through the 4-bit adder
//   DONE | result held with out_valid=1 until out_ready
module rca_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 sub,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int BW = $clog2(W);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry_reg;
    logic [IW-1:0]   idx;
    logic            ovf_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;

    logic [BW-1:0]   base;
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_sum;
    logic            nib_cout;

    assign base  = BW'(idx) << 2;
    assign nib_a = a_reg[base +: 4];
    assign nib_b = b_reg[base +: 4];

    ripplecarry4bit u_rca (
        .sum  (nib_sum),
        .cout (nib_cout),
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            carry_reg     <= 1'b0;
            sum_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= op_a;
                        b_reg        <= sub ? ~op_b : op_b;
                        carry_reg    <= sub ? 1'b1 : cin;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[base +: 4] <= nib_sum;
                    carry_reg          <= nib_cout;
                    idx                <= idx + IW'(1);
                    if (idx == LAST) begin
                        // Top nibble's sum bit is the final result MSB.
                        ovf_reg       <= (a_reg[W-1] == b_reg[W-1]) && (nib_sum[3] != a_reg[W-1]);
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = carry_reg;
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Scoreboard bench for rca_seq_ctrl: directed scenarios plus random ops,
// expected results from signed/unsigned integer arithmetic.

module tb_rca_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = -1;
    logic [W+1:0] exp_q[$];

    rca_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic c);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        longint r, sr;
        logic co;
        if (s) begin
            r  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(c);
            co = (r >= (longint'(1) << W));
            sr = sa + sb + longint'(c);
        end
        return {(sr > smax) || (sr < smin), co, W'(r)};
    endfunction

    // Carry (or no-borrow) out of the low k nibbles.
    function automatic logic carry_k(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic s, input logic c, input int k);
        longint m = longint'(1) << (4 * k);
        longint am = longint'(a) % m;
        longint bm = longint'(b) % m;
        if (s) return am >= bm;
        return (am + bm + longint'(c)) >= m;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("ready_low_in_done", in_ready, 0);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    chk("sum", sum, e[W-1:0]);
                    chk("cout", cout, e[W]);
                    chk("ovf", ovf, e[W+1]);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic c, input int hold, input bit abort);
        logic [W+1:0] e;
        int k;
        e = model(a, b, s, c);
        chk("ready_before_op", in_ready, 1);
        op_a = a; op_b = b; sub = s; cin = c; in_valid = 1'b1;
        @(posedge clk);
        if (!abort) exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        if (last_acc >= 0) chk("accept_spacing", (cyc - last_acc) >= 6, 1);
        last_acc = cyc;
        if (abort) begin
            repeat (2) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort_ready", in_ready, 1);
            chk("abort_valid", out_valid, 0);
            chk("abort_sum", sum, 0);
            last_acc = -1;
            return;
        end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k <= NIB) chk("carry_progress", cout, carry_k(a, b, s, c, k));
        end while (!out_valid && k < 20);
        chk("latency", k, NIB);
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", sum, e[W-1:0]);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle_ready", in_ready, 1);
        chk("back_idle_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Operation presented during reset must not be taken.
        in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        chk("rst_no_accept", in_ready, 1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
        run_op(16'hABCD, 16'h1357, 1'b0, 1'b1, 10, 1'b0);
        run_op(16'h0F0F, 16'h3C3C, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 0, 1'b1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
